// File: rtl/hazard_detection.sv
// ID-stage hazard/stall controller: load-use, branch-operand and MUL/DIV occupancy stalls.
// Optional stall statistics counter built only when HAZARD_STATS_EN is defined.
module hazard_detection #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IDRs,
  input  logic [4:0]  IDRt,
  input  logic        IDUsesRs,
  input  logic        IDUsesRt,
  input  logic        IDBranch,
  input  logic        IDReadsHiLo,
  input  logic        IDMulDiv,
  input  logic        BranchTaken,
  input  logic [4:0]  EXRd,
  input  logic        EXRegWrite,
  input  logic        EXMemRead,
  input  logic [4:0]  MEMRd,
  input  logic        MEMMemRead,
  input  logic        MulDivStart,
  input  logic        MulDivIsDiv,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXBubble,
  output logic        IFIDFlush,
  output logic        MulDivBusy,
  output logic        MulDivDone,
  output logic [31:0] StallCount
);

  typedef enum logic {IDLE, BUSY} md_state_t;

  localparam logic [CNT_W-1:0] MUL_M1 = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV_LAT - 1);

  md_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ex_rs, ex_rt, mem_rs, mem_rt;
  logic             load_use, br_ex, br_mem, md_haz, stall;

  // Register-0 destinations never create a dependence.
  assign ex_rs  = (EXRd  != 5'd0) && (EXRd  == IDRs) && IDUsesRs;
  assign ex_rt  = (EXRd  != 5'd0) && (EXRd  == IDRt) && IDUsesRt;
  assign mem_rs = (MEMRd != 5'd0) && (MEMRd == IDRs) && IDUsesRs;
  assign mem_rt = (MEMRd != 5'd0) && (MEMRd == IDRt) && IDUsesRt;

  assign load_use = EXMemRead & (ex_rs | ex_rt);
  assign br_ex    = IDBranch & EXRegWrite & (ex_rs | ex_rt);
  assign br_mem   = IDBranch & MEMMemRead & (mem_rs | mem_rt);
  assign md_haz   = MulDivBusy & (IDReadsHiLo | IDMulDiv);
  assign stall    = load_use | br_ex | br_mem | md_haz;

  assign PCWrite    = ~stall;
  assign IFIDWrite  = ~stall;
  assign IDEXBubble = stall;
  // A taken branch seen while stalled is resolved again once operands arrive.
  assign IFIDFlush  = BranchTaken & ~stall;

  assign MulDivBusy = (state == BUSY);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    MulDivDone = 1'b0;
    case (state)
      IDLE: begin
        if (MulDivStart) begin
          state_nxt = BUSY;
          cnt_nxt   = MulDivIsDiv ? DIV_M1 : MUL_M1;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          MulDivDone = 1'b1;
          if (MulDivStart) cnt_nxt = MulDivIsDiv ? DIV_M1 : MUL_M1;
          else             state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst)                                 stall_cnt <= '0;
    else if (stall && stall_cnt != '1)       stall_cnt <= stall_cnt + 32'd1;
  end

  assign StallCount = stall_cnt;
`else
  assign StallCount = '0;
`endif

endmodule
